writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the core; its outputs drive the register file write port (rd index and rd data).
- Registers MEM-stage results and aligns and sign-extends load data.
- Merges results from the long-latency multiply/divide unit through a one-entry pending buffer with starvation protection.
- Maintains the retired-instruction counter.

Parameters:
XLEN, 32, datapath width (matches rapid_pkg::XLEN)
STARVE_LIMIT, 4, cycles a buffered md result may wait before the stage forces a pipeline stall
CNT_W, 64, width of the retired-instruction counter

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_valid  in  1  MEM stage presents an instruction
i_rd  in  5  destination register (0 = no write)
i_wb_sel  in  2  wb_sel_e: WB_ALU, WB_LOAD, WB_PC4
i_alu_result  in  XLEN  ALU result
i_pc_plus4  in  XLEN  link value
i_load_data  in  XLEN  raw aligned memory word
i_funct3  in  3  load type
i_addr_lo  in  2  byte offset of load address
o_stall  out  1  upstream must hold MEM outputs this cycle
i_md_valid  in  1  md unit result valid
i_md_rd  in  5  md destination
i_md_result  in  XLEN  md result
o_md_ready  out  1  stage accepts md result
o_md_done  out  1  buffered md result written this cycle (scoreboard clear)
o_md_done_rd  out  5  rd of completed md result
o_rd  out  5  register file write index (0 = no write)
o_rd_data  out  XLEN  register file write data
o_instret  out  CNT_W  retired pipeline instruction count

Behaviour:
- Reset state:
  - WB register invalid; buffer empty; age counter 0; o_instret 0.
  - Hence o_rd=0, o_rd_data=0, o_stall=0, o_md_done=0, o_md_ready=1.
  - Reset mid-operation discards any buffered md result.
- WB register:
  - Captures the MEM inputs on posedge when o_stall=0.
  - When o_stall=1, loads a bubble (valid=0) instead; upstream holds its inputs.
  - Load data is aligned before capture, using funct3 and addr_lo:
    - LB (000): byte select, sign-extended. LBU (100): byte select, zero-extended.
    - LH (001) / LHU (101): halfword select at addr_lo[1], sign- or zero-extended.
    - LW (010): passthrough.
    - Other funct3 values: passthrough.
  - Misalignment is trapped upstream and never reaches this stage.
- Write port, combinational from state:
  - WB occupies the port (wb_has_write) when it is valid and its rd≠0. In that case o_rd=wb_rd and o_rd_data is the selected value.
  - Otherwise, if the buffer is valid, the buffer drains: o_rd=buf_rd, o_rd_data=buf_data, o_md_done=1, o_md_done_rd=buf_rd.
  - Otherwise o_rd=0 and o_rd_data=0.
- Register file timing: the register file commits at the next posedge and forwards same-cycle reads itself. MEM-to-regfile latency is 1 cycle of WB residency.
- md handshake:
  - o_md_ready = !buf_valid || draining.
  - A transfer occurs on posedge when i_md_valid && o_md_ready.
  - Drain and refill in the same cycle is legal; the buffer stays valid with the new entry.
  - The md unit holds valid/data until the transfer occurs.
- Starvation:
  - The age counter increments each cycle the buffer is valid and not draining, saturating at STARVE_LIMIT. It clears on drain and on refill.
  - o_stall = buf_valid && age==STARVE_LIMIT && wb_has_write.
  - Result: exactly one bubble is inserted, the buffer drains the next cycle, and the held instruction is captured at that drain edge.
- WAW ordering: the upstream scoreboard guarantees that no pipeline instruction targets an rd with an md result outstanding. This stage does not reorder.
- o_instret increments by 1 on each posedge where WB is valid, including rd=0 and bubble-free stores/branches. It wraps modulo 2^CNT_W.

Decomposition:
- rapid_pkg: wb_sel_e enum; LOAD_B/H/W/BU/HU funct3 constants; XLEN.
- Sub-module load_align (combinational: raw word, funct3, addr_lo -> XLEN value), instantiated once before the WB register.

Test Plan:
- LB, word 0x1234_80FF, addr_lo=1 -> next cycle o_rd_data=0xFFFF_FF80. LBU, same word and offset -> 0x0000_0080. LHU, addr_lo=2 -> 0x0000_1234.
- ALU write rd=5 data 0xA5A5_0000 with no md traffic -> o_rd=5 for one cycle; o_instret +1. rd=0 instruction -> o_rd=0, o_instret still +1.
- md result rd=9 data 7 arrives while WB holds a bubble -> next cycle o_rd=9, o_md_done=1, o_md_ready=1 throughout.
- Continuous ALU writes, md result rd=12 buffered:
  - o_md_ready=0 while buffered.
  - After STARVE_LIMIT=4 waiting cycles, o_stall=1 for exactly 1 cycle.
  - Next cycle o_rd=12, then the held instruction writes.
  - No instruction is lost or duplicated (instret check).
- Back-to-back md results during WB bubbles -> drain and refill each cycle, o_md_ready held at 1, results written in order.
- Assert i_reset with buffer full and age=3 -> o_rd=0, o_md_ready=1, o_instret=0 immediately; buffered result is never written.

Source files
------------

// File: rtl/rapid_pkg.sv
// Shared types and constants for the rapid core pipeline.
// Holds the writeback source select, load funct3 codes and datapath width.
// Imported by every writeback-stage file.
package rapid_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    localparam logic [2:0] LOAD_B  = 3'b000;
    localparam logic [2:0] LOAD_H  = 3'b001;
    localparam logic [2:0] LOAD_W  = 3'b010;
    localparam logic [2:0] LOAD_BU = 3'b100;
    localparam logic [2:0] LOAD_HU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load data alignment: picks the byte/halfword addressed by addr_lo and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
    import rapid_pkg::*;
#(
    parameter int XLEN = rapid_pkg::XLEN
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

    // Extend the selected lane; unknown funct3 codes pass the word through untouched.
    always_comb begin
        data_o = raw_i;
        case (funct3_i)
            LOAD_B:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LOAD_BU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
            LOAD_H:  data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            LOAD_HU: data_o = {{(XLEN-16){1'b0}}, half_sel};
            LOAD_W:  data_o = raw_i;
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: registers MEM results and merges multiply/divide results into the regfile write port.
// Latency: one cycle of WB residency for pipeline results; md results wait in a one-entry buffer for a free port.
// Backpressure: o_md_ready drops while the buffer is held; o_stall holds MEM for one cycle when a buffered md result is starved.
module writeback_stage
    import rapid_pkg::*;
#(
    parameter int XLEN         = rapid_pkg::XLEN,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [4:0]       i_rd,
    input  logic [1:0]       i_wb_sel,
    input  logic [XLEN-1:0]  i_alu_result,
    input  logic [XLEN-1:0]  i_pc_plus4,
    input  logic [XLEN-1:0]  i_load_data,
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_addr_lo,
    output logic             o_stall,
    input  logic             i_md_valid,
    input  logic [4:0]       i_md_rd,
    input  logic [XLEN-1:0]  i_md_result,
    output logic             o_md_ready,
    output logic             o_md_done,
    output logic [4:0]       o_md_done_rd,
    output logic [4:0]       o_rd,
    output logic [XLEN-1:0]  o_rd_data,
    output logic [CNT_W-1:0] o_instret
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic             wb_valid_q;
    logic [4:0]       wb_rd_q;
    logic [XLEN-1:0]  wb_data_q;
    logic [XLEN-1:0]  wb_data_d;

    logic             buf_valid_q;
    logic [4:0]       buf_rd_q;
    logic [XLEN-1:0]  buf_data_q;
    logic [AGE_W-1:0] age_q;
    logic [CNT_W-1:0] instret_q;

    logic [XLEN-1:0]  load_val;
    logic             wb_has_write;
    logic             draining;
    logic             md_xfer;
    wb_sel_e          sel;

    load_align #(.XLEN(XLEN)) u_load_align (
        .raw_i     (i_load_data),
        .funct3_i  (i_funct3),
        .addr_lo_i (i_addr_lo),
        .data_o    (load_val)
    );

    assign sel          = wb_sel_e'(i_wb_sel);
    assign wb_has_write = wb_valid_q && (wb_rd_q != 5'd0);
    // The buffer only gets the port when the pipeline instruction does not need it.
    assign draining     = buf_valid_q && !wb_has_write;
    assign o_md_ready   = !buf_valid_q || draining;
    assign md_xfer      = i_md_valid && o_md_ready;
    // Starved buffer: steal one slot from the pipeline so the buffer drains next cycle.
    assign o_stall      = buf_valid_q && (age_q == AGE_MAX) && wb_has_write;

    // Choose the value the pipeline instruction will write, resolved before capture.
    always_comb begin
        wb_data_d = i_alu_result;
        case (sel)
            WB_ALU:  wb_data_d = i_alu_result;
            WB_LOAD: wb_data_d = load_val;
            WB_PC4:  wb_data_d = i_pc_plus4;
            default: wb_data_d = i_alu_result;
        endcase
    end

    // WB register: capture MEM results, or insert a bubble while MEM is held.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
        end else if (o_stall) begin
            wb_valid_q <= 1'b0;
        end else begin
            wb_valid_q <= i_valid;
            wb_rd_q    <= i_rd;
            wb_data_q  <= wb_data_d;
        end
    end

    // One-entry md buffer with age tracking; drain and refill may coincide.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            buf_valid_q <= 1'b0;
            buf_rd_q    <= 5'd0;
            buf_data_q  <= '0;
            age_q       <= '0;
        end else begin
            if (md_xfer) begin
                buf_valid_q <= 1'b1;
                buf_rd_q    <= i_md_rd;
                buf_data_q  <= i_md_result;
            end else if (draining) begin
                buf_valid_q <= 1'b0;
            end
            if (md_xfer || draining) begin
                age_q <= '0;
            end else if (buf_valid_q && (age_q != AGE_MAX)) begin
                age_q <= age_q + AGE_W'(1);
            end
        end
    end

    // Count every valid pipeline instruction leaving WB, including rd=0 ones.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            instret_q <= '0;
        end else if (wb_valid_q) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Register file write port: pipeline first, then the buffered md result.
    always_comb begin
        o_rd         = 5'd0;
        o_rd_data    = '0;
        o_md_done    = 1'b0;
        o_md_done_rd = 5'd0;
        if (wb_has_write) begin
            o_rd      = wb_rd_q;
            o_rd_data = wb_data_q;
        end else if (buf_valid_q) begin
            o_rd         = buf_rd_q;
            o_rd_data    = buf_data_q;
            o_md_done    = 1'b1;
            o_md_done_rd = buf_rd_q;
        end
    end

    assign o_instret = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
    import rapid_pkg::*;

    localparam int LIMIT = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [4:0]  i_rd;
    logic [1:0]  i_wb_sel;
    logic [31:0] i_alu_result, i_pc_plus4, i_load_data;
    logic [2:0]  i_funct3;
    logic [1:0]  i_addr_lo;
    logic        o_stall;
    logic        i_md_valid;
    logic [4:0]  i_md_rd;
    logic [31:0] i_md_result;
    logic        o_md_ready, o_md_done;
    logic [4:0]  o_md_done_rd, o_rd;
    logic [31:0] o_rd_data;
    logic [63:0] o_instret;

    writeback_stage #(.XLEN(32), .STARVE_LIMIT(LIMIT), .CNT_W(64)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_rd(i_rd),
        .i_wb_sel(i_wb_sel), .i_alu_result(i_alu_result), .i_pc_plus4(i_pc_plus4),
        .i_load_data(i_load_data), .i_funct3(i_funct3), .i_addr_lo(i_addr_lo),
        .o_stall(o_stall), .i_md_valid(i_md_valid), .i_md_rd(i_md_rd),
        .i_md_result(i_md_result), .o_md_ready(o_md_ready), .o_md_done(o_md_done),
        .o_md_done_rd(o_md_done_rd), .o_rd(o_rd), .o_rd_data(o_rd_data),
        .o_instret(o_instret)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_wb_v;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    logic [4:0]  m_buf_rd[$];
    logic [31:0] m_buf_data[$];
    int          m_wait;
    logic [63:0] m_instret;

    function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
        int unsigned b, h;
        b = (w >> (int'(lo) * 8)) & 32'hFF;
        h = (w >> ((int'(lo) / 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0: return (b < 128) ? b : b - 256;
            3'd4: return b;
            3'd1: return (h < 32768) ? h : h - 65536;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_value();
        if (i_wb_sel == 2'd1) return ref_align(i_load_data, i_funct3, i_addr_lo);
        if (i_wb_sel == 2'd2) return i_pc_plus4;
        return i_alu_result;
    endfunction

    task automatic model_reset();
        m_wb_v = 0; m_wb_rd = 0; m_wb_data = 0;
        m_buf_rd.delete(); m_buf_data.delete();
        m_wait = 0; m_instret = 0;
    endtask

    task automatic model_step();
        bit pipe_writes, has, drain, starve, ready, xfer;
        pipe_writes = m_wb_v && (m_wb_rd != 0);
        has    = m_buf_rd.size() != 0;
        drain  = has && !pipe_writes;
        starve = has && (m_wait == LIMIT) && pipe_writes;
        ready  = !has || drain;
        xfer   = i_md_valid && ready;
        if (m_wb_v) m_instret = m_instret + 1;
        if (drain) begin
            void'(m_buf_rd.pop_front());
            void'(m_buf_data.pop_front());
        end
        if (xfer) begin
            m_buf_rd.push_back(i_md_rd);
            m_buf_data.push_back(i_md_result);
        end
        if (xfer || drain) m_wait = 0;
        else if (has && m_wait < LIMIT) m_wait = m_wait + 1;
        if (starve) m_wb_v = 0;
        else begin
            m_wb_v    = i_valid;
            m_wb_rd   = i_rd;
            m_wb_data = ref_value();
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or posedge i_reset);
            if (i_reset) model_reset();
            else model_step();
        end
    end

    // Single compare process: all outputs every cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge i_clk);
            begin
                bit pw, has;
                logic [4:0]  e_rd;
                logic [31:0] e_dat;
                pw  = m_wb_v && (m_wb_rd != 0);
                has = m_buf_rd.size() != 0;
                e_rd = 0; e_dat = 0;
                if (pw) begin e_rd = m_wb_rd; e_dat = m_wb_data; end
                else if (has) begin e_rd = m_buf_rd[0]; e_dat = m_buf_data[0]; end
                chk("m_rd", 64'(o_rd), 64'(e_rd));
                chk("m_rd_data", 64'(o_rd_data), 64'(e_dat));
                chk("m_stall", 64'(o_stall), 64'(has && m_wait == LIMIT && pw));
                chk("m_md_ready", 64'(o_md_ready), 64'(!has || !pw));
                chk("m_md_done", 64'(o_md_done), 64'(has && !pw));
                if (has && !pw) chk("m_md_done_rd", 64'(o_md_done_rd), 64'(m_buf_rd[0]));
                chk("m_instret", o_instret, m_instret);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_valid = 0; i_rd = 0; i_wb_sel = 0; i_alu_result = 0; i_pc_plus4 = 0;
        i_load_data = 0; i_funct3 = 0; i_addr_lo = 0;
        i_md_valid = 0; i_md_rd = 0; i_md_result = 0;
    endtask

    task automatic put_alu(input logic [4:0] rd, input logic [31:0] d);
        i_valid = 1; i_rd = rd; i_wb_sel = 2'd0; i_alu_result = d;
    endtask

    task automatic put_load(input logic [4:0] rd, input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
        i_valid = 1; i_rd = rd; i_wb_sel = 2'd1; i_load_data = w; i_funct3 = f3; i_addr_lo = lo;
    endtask

    task automatic rand_mem(input int dens);
        int k;
        i_valid      = ($urandom_range(99) < dens);
        i_rd         = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        i_wb_sel     = 2'($urandom_range(2));
        i_alu_result = $urandom;
        i_pc_plus4   = $urandom;
        i_load_data  = $urandom;
        k = $urandom_range(6);
        case (k)
            0: i_funct3 = 3'd0; 1: i_funct3 = 3'd4; 2: i_funct3 = 3'd1;
            3: i_funct3 = 3'd5; 4: i_funct3 = 3'd2; 5: i_funct3 = 3'd3;
            default: i_funct3 = 3'd6;
        endcase
        if (i_funct3 == 3'd1 || i_funct3 == 3'd5) i_addr_lo = {1'($urandom_range(1)), 1'b0};
        else if (i_funct3 == 3'd2) i_addr_lo = 2'd0;
        else i_addr_lo = 2'($urandom_range(3));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] cnt0;
        int stalls, stall_at, drain_at, acc_cnt, done_seen, ready_low, k;
        logic [4:0] held_rd;
        bit md_pending, st, md_acc, check_held;

        idle();
        i_reset = 1;
        #3;
        chk("reset_rd", 64'(o_rd), 64'd0);
        chk("reset_rd_data", 64'(o_rd_data), 64'd0);
        chk("reset_stall", 64'(o_stall), 64'd0);
        chk("reset_md_done", 64'(o_md_done), 64'd0);
        chk("reset_md_ready", 64'(o_md_ready), 64'd1);
        chk("reset_instret", o_instret, 64'd0);
        cyc(); cyc();
        i_reset = 0;
        cyc();

        // Load alignment
        put_load(5'd3, 32'h1234_80FF, 3'd0, 2'd1); cyc(); i_valid = 0;
        chk("lb_rd", 64'(o_rd), 64'd3);
        chk("lb_data", 64'(o_rd_data), 64'hFFFF_FF80);
        put_load(5'd3, 32'h1234_80FF, 3'd4, 2'd1); cyc(); i_valid = 0;
        chk("lbu_data", 64'(o_rd_data), 64'h0000_0080);
        put_load(5'd4, 32'h1234_80FF, 3'd5, 2'd2); cyc(); i_valid = 0;
        chk("lhu_data", 64'(o_rd_data), 64'h0000_1234);
        put_load(5'd4, 32'h1234_80FF, 3'd1, 2'd0); cyc(); i_valid = 0;
        chk("lh_data", 64'(o_rd_data), 64'hFFFF_80FF);
        cyc();

        // ALU write and rd=0 instruction
        cnt0 = o_instret;
        put_alu(5'd5, 32'hA5A5_0000); cyc(); i_valid = 0;
        chk("alu_rd", 64'(o_rd), 64'd5);
        chk("alu_data", 64'(o_rd_data), 64'hA5A5_0000);
        cyc();
        chk("alu_gone", 64'(o_rd), 64'd0);
        chk("alu_instret", o_instret, cnt0 + 1);
        put_alu(5'd0, 32'h1111_2222); cyc(); i_valid = 0;
        chk("rd0_rd", 64'(o_rd), 64'd0);
        cyc();
        chk("rd0_instret", o_instret, cnt0 + 2);

        // md result into an idle WB
        i_md_valid = 1; i_md_rd = 5'd9; i_md_result = 32'd7;
        chk("md9_ready_before", 64'(o_md_ready), 64'd1);
        cyc(); i_md_valid = 0;
        chk("md9_rd", 64'(o_rd), 64'd9);
        chk("md9_data", 64'(o_rd_data), 64'd7);
        chk("md9_done", 64'(o_md_done), 64'd1);
        chk("md9_done_rd", 64'(o_md_done_rd), 64'd9);
        chk("md9_ready", 64'(o_md_ready), 64'd1);
        cyc();
        chk("md9_gone", 64'(o_md_done), 64'd0);

        // Starvation: continuous ALU writes with md rd=12 buffered
        cnt0 = o_instret;
        k = 0; acc_cnt = 0; stalls = 0; stall_at = -1; drain_at = -1; ready_low = 0;
        held_rd = 0; check_held = 0;
        put_alu(5'((k % 8) + 1), 32'h1000 + k);
        i_md_valid = 1; i_md_rd = 5'd12; i_md_result = 32'hBEEF; md_pending = 1;
        for (int c = 0; c < 14; c++) begin
            st = o_stall;
            if (st) begin stalls++; stall_at = c; held_rd = i_rd; end
            if (c >= 1 && c <= 5 && !o_md_ready) ready_low++;
            md_acc = md_pending && o_md_ready;
            if (!st && i_valid) acc_cnt++;
            cyc();
            if (check_held) begin
                chk("starve_held_rd", 64'(o_rd), 64'(held_rd));
                check_held = 0;
            end
            if (md_acc) begin md_pending = 0; i_md_valid = 0; end
            if (o_md_done && o_md_done_rd == 5'd12) begin drain_at = c; check_held = 1; end
            if (!st) begin k++; put_alu(5'((k % 8) + 1), 32'h1000 + k); end
        end
        i_valid = 0;
        cyc(); cyc();
        chk("starve_stall_count", 64'(stalls), 64'd1);
        chk("starve_stall_cycle", 64'(stall_at), 64'd5);
        chk("starve_drain_cycle", 64'(drain_at), 64'd5);
        chk("starve_ready_low", 64'(ready_low), 64'd5);
        chk("starve_instret", o_instret, cnt0 + 64'(acc_cnt));

        // Back-to-back md results during bubbles
        for (int i = 0; i < 5; i++) begin
            i_md_valid = 1; i_md_rd = 5'(20 + i); i_md_result = 32'h100 + i;
            chk("b2b_ready", 64'(o_md_ready), 64'd1);
            cyc();
            chk("b2b_rd", 64'(o_rd), 64'(20 + i));
            chk("b2b_data", 64'(o_rd_data), 64'(32'h100 + i));
        end
        i_md_valid = 0;
        cyc();
        chk("b2b_empty", 64'(o_md_done), 64'd0);

        // Reset with buffer full and age 3
        put_alu(5'd1, 32'h55);
        i_md_valid = 1; i_md_rd = 5'd30; i_md_result = 32'hDEAD;
        cyc(); i_md_valid = 0;
        for (int i = 0; i < 3; i++) begin put_alu(5'(2 + i), 32'h60 + i); cyc(); end
        chk("pre_reset_ready", 64'(o_md_ready), 64'd0);
        #2 i_reset = 1;
        #1;
        chk("rst_rd", 64'(o_rd), 64'd0);
        chk("rst_data", 64'(o_rd_data), 64'd0);
        chk("rst_ready", 64'(o_md_ready), 64'd1);
        chk("rst_instret", o_instret, 64'd0);
        idle();
        #1 i_reset = 0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (o_md_done || o_rd == 5'd30) done_seen++;
        end
        chk("rst_buffer_discarded", 64'(done_seen), 64'd0);

        // Randomized traffic in segments of varying pressure
        for (int seg = 0; seg < 5; seg++) begin
            int dens, mdp;
            case (seg)
                0: begin dens = 50;  mdp = 30;  end
                1: begin dens = 95;  mdp = 60;  end
                2: begin dens = 100; mdp = 100; end
                3: begin dens = 20;  mdp = 80;  end
                default: begin dens = 90; mdp = 10; end
            endcase
            rand_mem(dens);
            for (int c = 0; c < 600; c++) begin
                bit acc_mem, acc_md;
                acc_mem = !o_stall;
                acc_md  = i_md_valid && o_md_ready;
                cyc();
                if (acc_mem) rand_mem(dens);
                if (acc_md || !i_md_valid) begin
                    if ($urandom_range(99) < mdp) begin
                        i_md_valid  = 1;
                        i_md_rd     = 5'($urandom_range(31, 1));
                        i_md_result = $urandom;
                    end else begin
                        i_md_valid = 0;
                    end
                end
            end
        end
        idle();
        cyc(); cyc(); cyc();
        @(negedge i_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
